// File: rtl/pipeline_stage_elastic.sv
// pipeline_stage_elastic: elastic pipeline register with flush and optional skid buffer; PIPE_STAGE_STATS_EN adds stall_cycles/xfer_count
module pipeline_stage_elastic #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] BUBBLE_V = '0,
   parameter int SKID = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      xfer_count
`endif
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] main_q, main_n, skid_q, skid_n;
   logic rdy_q, in_fire, out_fire;
   // skid mode: ready comes from a flop, so out_ready never reaches in_ready
   assign in_ready = (SKID != 0) ? (rdy_q & !flush) : (!flush & (!out_valid | out_ready));
   assign in_fire = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign out_data = main_q;
   assign occupancy = state;
   always_comb begin
      state_n = state;
      main_n = main_q;
      skid_n = skid_q;
      if (flush) begin
         state_n = EMPTY;
         main_n = BUBBLE_V;
         skid_n = BUBBLE_V;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               main_n = in_data;
               state_n = ONE;
            end
            ONE: if (in_fire && out_fire) begin
               main_n = in_data;
            end else if (in_fire) begin
               skid_n = in_data;
               state_n = TWO;
            end else if (out_fire) begin
               main_n = BUBBLE_V;
               state_n = EMPTY;
            end
            TWO: if (out_fire) begin
               main_n = skid_q;
               skid_n = BUBBLE_V;
               state_n = ONE;
            end
            default: begin
               state_n = EMPTY;
               main_n = BUBBLE_V;
               skid_n = BUBBLE_V;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
         main_q <= BUBBLE_V;
         skid_q <= BUBBLE_V;
         out_valid <= 1'b0;
         rdy_q <= 1'b1;
      end else begin
         state <= state_n;
         main_q <= main_n;
         skid_q <= skid_n;
         out_valid <= (state_n != EMPTY);
         rdy_q <= (state_n != TWO);
      end
   end
`ifdef PIPE_STAGE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         xfer_count <= '0;
      end else begin
         if (out_valid && !out_ready && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
         if (out_fire) xfer_count <= xfer_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// tb_pipeline_stage_elastic: scoreboard bench driving a SKID=1 (index 0) and a SKID=0 (index 1) instance
module tb_pipeline_stage_elastic;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] iv, orr, fl, ir, ov;
   logic [7:0] id [2];
   logic [7:0] od [2];
   logic [1:0] occ [2];
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stc [2];
   logic [31:0] xfc [2];
`endif
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   pipeline_stage_elastic #(.WIDTH(8), .BUBBLE_V(8'hA5), .SKID(1)) u_skid (
      .clk(clk), .reset(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
      .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .occupancy(occ[0])
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cycles(stc[0]), .xfer_count(xfc[0])
`endif
   );
   pipeline_stage_elastic #(.WIDTH(8), .BUBBLE_V(8'hA5), .SKID(0)) u_noskid (
      .clk(clk), .reset(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
      .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .occupancy(occ[1])
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cycles(stc[1]), .xfer_count(xfc[1])
`endif
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic push(input int d, input logic [7:0] v);
      if (d == 0) q0.push_back(v);
      else q1.push_back(v);
   endtask
   task automatic drive(input int d, input logic v, input logic [7:0] data, input logic r, input logic f);
      iv[d] = v;
      id[d] = data;
      orr[d] = r;
      fl[d] = f;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // pops the oldest expected entry on every out-fire; an idle output must show the bubble
   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int d = 0; d < 2; d++) begin
               if (ov[d] && orr[d]) begin
                  if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL unexpected_out[%0d]: got %0h, expected no entry", d, od[d]);
                  end else begin
                     e = (d == 0) ? q0.pop_front() : q1.pop_front();
                     chk($sformatf("out_data[%0d]", d), {24'd0, od[d]}, {24'd0, e});
                  end
               end else if (!ov[d]) begin
                  chk($sformatf("bubble[%0d]", d), {24'd0, od[d]}, 32'hA5);
               end
            end
         end
      end
   endtask
   initial begin
`ifdef PIPE_STAGE_STATS_EN
      logic [31:0] s0, x0;
`endif
      fork
         monitor();
         begin
            #200000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1);
         end
      join_none
      rst = 1'b1;
      iv = '0; orr = '0; fl = '0;
      id[0] = '0; id[1] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_valid[%0d]", d), {31'd0, ov[d]}, 0);
         chk($sformatf("rst_data[%0d]", d), {24'd0, od[d]}, 32'hA5);
         chk($sformatf("rst_occ[%0d]", d), {30'd0, occ[d]}, 0);
         chk($sformatf("rst_ready[%0d]", d), {31'd0, ir[d]}, 1);
      end
      // fill the skid buffer while stalled, then drain in order
      drive(0, 1, 8'h11, 0, 0); push(0, 8'h11); cyc();
      chk("t2_occ1", {30'd0, occ[0]}, 1);
      chk("t2_ready1", {31'd0, ir[0]}, 1);
      drive(0, 1, 8'h22, 0, 0); push(0, 8'h22); cyc();
      chk("t2_occ2", {30'd0, occ[0]}, 2);
      chk("t2_ready2", {31'd0, ir[0]}, 0);
      drive(0, 0, 8'h00, 1, 0); cyc();
      chk("t2_drain1_occ", {30'd0, occ[0]}, 1);
      chk("t2_drain1_data", {24'd0, od[0]}, 32'h22);
      cyc();
      chk("t2_empty_valid", {31'd0, ov[0]}, 0);
      chk("t2_empty_data", {24'd0, od[0]}, 32'hA5);
      chk("t2_empty_occ", {30'd0, occ[0]}, 0);
      // full throughput in both modes
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 10; i++) begin
            drive(d, 1, 8'(i), 1, 0);
            #1 chk($sformatf("t3_ready[%0d]", d), {31'd0, ir[d]}, 1);
            push(d, 8'(i));
            cyc();
            chk($sformatf("t3_occ[%0d]", d), {30'd0, occ[d]}, 1);
            chk($sformatf("t3_data[%0d]", d), {24'd0, od[d]}, i);
         end
         drive(d, 0, 8'h00, 1, 0); cyc();
         chk($sformatf("t3_end_occ[%0d]", d), {30'd0, occ[d]}, 0);
         drive(d, 0, 8'h00, 0, 0);
      end
      // flush from TWO with a competing input that must be dropped
      drive(0, 1, 8'h33, 0, 0); push(0, 8'h33); cyc();
      drive(0, 1, 8'h44, 0, 0); push(0, 8'h44); cyc();
      chk("t4_occ2", {30'd0, occ[0]}, 2);
      drive(0, 1, 8'h55, 0, 1);
      #1 chk("t4_flush_ready", {31'd0, ir[0]}, 0);
      q0.delete();
      cyc();
      drive(0, 0, 8'h00, 1, 0);
      chk("t4_occ0", {30'd0, occ[0]}, 0);
      chk("t4_data", {24'd0, od[0]}, 32'hA5);
      chk("t4_valid", {31'd0, ov[0]}, 0);
      cyc(); cyc();
      drive(0, 1, 8'h66, 1, 0); push(0, 8'h66); cyc();
      chk("t4_after_data", {24'd0, od[0]}, 32'h66);
      drive(0, 0, 8'h00, 1, 0); cyc();
      drive(0, 0, 8'h00, 0, 0);
      // SKID=0: in_ready follows out_ready combinationally
      drive(1, 1, 8'h77, 0, 0); push(1, 8'h77); cyc();
      drive(1, 1, 8'h88, 0, 0);
      #1 chk("t5_ready_low", {31'd0, ir[1]}, 0);
      cyc();
      chk("t5_hold_data", {24'd0, od[1]}, 32'h77);
      chk("t5_hold_occ", {30'd0, occ[1]}, 1);
      drive(1, 1, 8'h88, 1, 0);
      #1 chk("t5_ready_high", {31'd0, ir[1]}, 1);
      push(1, 8'h88); cyc();
      chk("t5_new_data", {24'd0, od[1]}, 32'h88);
      chk("t5_new_occ", {30'd0, occ[1]}, 1);
      drive(1, 0, 8'h00, 1, 0); cyc();
      drive(1, 0, 8'h00, 0, 0);
`ifdef PIPE_STAGE_STATS_EN
      s0 = stc[0];
      x0 = xfc[0];
      drive(0, 1, 8'hAA, 0, 0); push(0, 8'hAA); cyc();
      drive(0, 0, 8'h00, 0, 0);
      repeat (5) cyc();
      drive(0, 1, 8'hBB, 1, 0); push(0, 8'hBB); cyc();
      drive(0, 1, 8'hCC, 1, 0); push(0, 8'hCC); cyc();
      drive(0, 0, 8'h00, 1, 0); cyc();
      chk("t6_stall", stc[0] - s0, 5);
      chk("t6_xfer", xfc[0] - x0, 3);
      drive(0, 0, 8'h00, 0, 1); cyc();
      drive(0, 0, 8'h00, 0, 0);
      chk("t6_stall_flush", stc[0] - s0, 5);
      chk("t6_xfer_flush", xfc[0] - x0, 3);
`endif
      cyc(); cyc();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pipeline_stage_elastic.md
Name: pipeline_stage_elastic

Overview:
Generic, parametrised pipeline stage register. It replaces the per-signal stall/bubble register bundles used between the D/E/M/W stages with one block that carries a packed payload.
- Adds a valid/ready handshake, a flush (bubble) that clears in-flight entries, and an optional 2-entry skid buffer so in_ready is a registered signal.
- Sits between any two pipeline stages. Stage wrappers pack their fields into in_data.

Parameters:
WIDTH, 32, payload width in bits (1..256).
BUBBLE_V, 0, WIDTH-bit value driven on out_data whenever the stage holds no valid entry (after reset, flush, or drain).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  bubble request: discard all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage holds a valid head entry
out_ready  input  1  downstream accepts the head entry this cycle
out_data  output  WIDTH  head payload; BUBBLE_V when out_valid=0
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Handshake terms:
  - in-fire = in_valid & in_ready & !flush.
  - out-fire = out_valid & out_ready.
  - Producer must hold in_data stable while in_valid=1 and in_ready=0. in_valid may drop without a fire.
- Reset, checked at the clock edge:
  - State goes to EMPTY.
  - out_valid=0, out_data=BUBBLE_V, occupancy=0, skid register=BUBBLE_V.
  - in_ready=1 (SKID=1) or follows its SKID=0 equation.
- Priority: reset > flush > normal operation.
- Flush:
  - Next state is EMPTY, regardless of state, in_valid or out_ready.
  - in_ready is forced 0 while flush=1, so no in-fire can occur.
  - An out-fire in the flush cycle is still valid for downstream. The entry is consumed, not replayed.
- SKID=1, FSM states EMPTY (0 entries), ONE (main register valid), TWO (main + skid valid):
  - EMPTY: in-fire -> main<=in_data, ONE.
  - ONE, in-fire & out-fire -> main<=in_data, stay ONE.
  - ONE, in-fire only -> skid<=in_data, TWO.
  - ONE, out-fire only -> EMPTY, main<=BUBBLE_V.
  - TWO: out-fire -> main<=skid, skid<=BUBBLE_V, ONE. No in-fire is possible because in_ready=0.
  - in_ready = (state != TWO), driven from a register. No combinational path from out_ready to in_ready.
  - Order is preserved: the skid entry is always younger than main.
- SKID=0:
  - in_ready = !flush & (!out_valid | out_ready), combinational.
  - in-fire loads main (valid=1).
  - out-fire without in-fire clears main to BUBBLE_V.
  - States EMPTY/ONE only.
- Latency:
  - Minimum 1 cycle from in-fire to out_valid.
  - Full throughput of 1 entry/cycle with out_ready held at 1 in both modes.
- occupancy reflects the registered state, updated 1 cycle after the causing fire.
- out_data and out_valid come directly from flops. No combinational path from inputs to them.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined: adds two output ports.
  - stall_cycles[31:0]: increments every cycle with out_valid=1 & out_ready=0. Saturates at 0xFFFFFFFF.
  - xfer_count[31:0]: increments on every out-fire. Wraps modulo 2^32.
  - Both counters clear on reset only; flush does not clear them.
- Not defined: both ports and counters are absent. Behaviour of all other ports is identical.

Test Plan:
1. Reset with WIDTH=8, BUBBLE_V=8'hA5 -> out_valid=0, out_data=8'hA5, occupancy=0, in_ready=1 (SKID=1).
2. SKID=1, out_ready=0, push 8'h11 then 8'h22:
   - occupancy goes 1 then 2; in_ready=0 the cycle after the second fire.
   - Raise out_ready -> out_data 8'h11 then 8'h22 on consecutive cycles, then out_valid=0, out_data=8'hA5.
3. Both modes, in_valid=1 and out_ready=1 for 10 cycles with data 0..9 -> out_data 0..9 on consecutive cycles after 1-cycle latency; occupancy stays 1.
4. SKID=1 in state TWO (entries 8'h33, 8'h44), assert flush with in_valid=1 and in_data=8'h55:
   - in_ready=0 in that cycle; next cycle occupancy=0 and out_data=8'hA5.
   - 8'h55 never appears on out_data.
5. SKID=0, out_valid=1, out_ready=0 -> in_ready=0 combinationally; raise out_ready with in_valid=1 -> in_ready=1 in the same cycle and the new entry is loaded.
6. PIPE_STAGE_STATS_EN defined: hold one entry with out_ready=0 for 5 cycles, then 3 out-fires -> stall_cycles=5, xfer_count=3; assert flush -> both counts unchanged.
